// File: rtl/switch_debouncer.sv
// ----------------------------------------------------------------------------
// switch_debouncer
//   Input conditioning for raw board switches feeding the memory-mapped I/O
//   block. Each bit passes through a 2-flop synchroniser and then a
//   stability filter. A new level is accepted only after the synchronised
//   input has differed from the current debounced level for STABLE_CYCLES
//   consecutive clock edges. Each accepted change also emits a one-cycle
//   rise or fall pulse for that bit.
//
// Parameters
//   N_SW           number of switch bits (>= 1)
//   STABLE_CYCLES  consecutive mismatched edges needed to accept (>= 1)
//
// Ports
//   clk         system clock, all flops on the rising edge
//   reset_n     synchronous active-low reset
//   sw_raw      raw switch pins, asynchronous to clk
//   sw_db       debounced level (registered)
//   sw_rise     one-cycle pulse per bit on an accepted 0->1 change (registered)
//   sw_fall     one-cycle pulse per bit on an accepted 1->0 change (registered)
//   any_change  OR of all rise/fall pulses
// ----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int N_SW          = 4,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            any_change
);

  // Counter wide enough to hold STABLE_CYCLES-1. The guard keeps the width
  // legal so that the parameter error below is what reports a bad setting.
  localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (STABLE_CYCLES < 1 || N_SW < 1) begin : g_param_err
    $error("switch_debouncer: STABLE_CYCLES and N_SW must both be >= 1");
  end

  logic [N_SW-1:0]  sync1_r;
  logic [N_SW-1:0]  sync2_r;
  logic [CNT_W-1:0] cnt_r [N_SW];

  // Synchroniser chain plus per-bit stability counters and event pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
      sw_db   <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      for (int i = 0; i < N_SW; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= sw_raw;
      sync2_r <= sync1_r;
      for (int i = 0; i < N_SW; i++) begin
        if (sync2_r[i] == sw_db[i]) begin
          // Input agrees with the accepted level: any mismatch run is over.
          cnt_r[i]   <= '0;
          sw_rise[i] <= 1'b0;
          sw_fall[i] <= 1'b0;
        end else if (cnt_r[i] == CNT_MAX) begin
          // Mismatch has held long enough: take the new level and flag it.
          sw_db[i]   <= sync2_r[i];
          cnt_r[i]   <= '0;
          sw_rise[i] <= sync2_r[i];
          sw_fall[i] <= ~sync2_r[i];
        end else begin
          cnt_r[i]   <= cnt_r[i] + CNT_ONE;
          sw_rise[i] <= 1'b0;
          sw_fall[i] <= 1'b0;
        end
      end
    end
  end

  // Pulses are registered, so this OR adds no extra state.
  assign any_change = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_switch_debouncer.sv
// ----------------------------------------------------------------------------
// tb_switch_debouncer
//   Drives two debouncers (STABLE_CYCLES = 4 and 1) from the same raw inputs
//   and compares them every cycle against a window-based reference: a bit
//   flips when each of the last STABLE_CYCLES synchronised samples differs
//   from the accepted level and no reset or earlier acceptance of that bit
//   falls inside that window.
// ----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int N  = 4;
  localparam int HM = 16;   // history ring, larger than any window used

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] sw_raw;

  logic [N-1:0] db4, rise4, fall4, db1, rise1, fall1;
  logic         any4, any1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_debouncer #(.N_SW(N), .STABLE_CYCLES(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
    .sw_db(db4), .sw_rise(rise4), .sw_fall(fall4), .any_change(any4)
  );

  switch_debouncer #(.N_SW(N), .STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
    .sw_db(db1), .sw_rise(rise1), .sw_fall(fall1), .any_change(any1)
  );

  // Reference model state, index 0 -> STABLE_CYCLES=4, index 1 -> 1.
  logic [N-1:0] m_sync1 [2];
  logic [N-1:0] m_sync2 [2];
  logic [N-1:0] m_db    [2];
  logic [N-1:0] m_rise  [2];
  logic [N-1:0] m_fall  [2];
  logic [N-1:0] s_hist  [2][HM];
  int           m_last  [2][N];
  int           edge_n = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_step();
    int  sc;
    int  e;
    bit  ok;
    edge_n++;
    for (int m = 0; m < 2; m++) begin
      sc = (m == 0) ? 4 : 1;
      if (!reset_n) begin
        m_sync1[m] = '0;
        m_sync2[m] = '0;
        m_db[m]    = '0;
        m_rise[m]  = '0;
        m_fall[m]  = '0;
        for (int b = 0; b < N; b++) m_last[m][b] = edge_n;
      end else begin
        s_hist[m][edge_n % HM] = m_sync2[m];
        m_rise[m] = '0;
        m_fall[m] = '0;
        for (int b = 0; b < N; b++) begin
          ok = 1'b1;
          for (int j = 0; j < sc; j++) begin
            e = edge_n - j;
            if (e <= m_last[m][b] || s_hist[m][e % HM][b] == m_db[m][b]) ok = 1'b0;
          end
          if (ok) begin
            m_db[m][b] = ~m_db[m][b];
            if (m_db[m][b]) m_rise[m][b] = 1'b1;
            else            m_fall[m][b] = 1'b1;
            m_last[m][b] = edge_n;
          end
        end
        m_sync2[m] = m_sync1[m];
        m_sync1[m] = sw_raw;
      end
    end
  endtask

  task automatic compare_all();
    check_val("db4",   32'(db4),   32'(m_db[0]));
    check_val("rise4", 32'(rise4), 32'(m_rise[0]));
    check_val("fall4", 32'(fall4), 32'(m_fall[0]));
    check_val("any4",  32'(any4),  32'(|(m_rise[0] | m_fall[0])));
    check_val("db1",   32'(db1),   32'(m_db[1]));
    check_val("rise1", 32'(rise1), 32'(m_rise[1]));
    check_val("fall1", 32'(fall1), 32'(m_fall[1]));
    check_val("any1",  32'(any1),  32'(|(m_rise[1] | m_fall[1])));
  endtask

  // One clock: model advances at the edge, outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic [N-1:0] raw, input int cycles);
    sw_raw = raw;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    sw_raw  = 4'hF;

    // Start-up: reset held with all switches high, then release.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_db4",    32'(db4),           32'h0);
      check_val("rst_pulse4", 32'(rise4 | fall4), 32'h0);
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 3) check_val("start_db1_e3", 32'(db1), 32'hF);
      if (i == 5) check_val("start_db4_e5", 32'(db4), 32'h0);
      if (i == 6) begin
        check_val("start_db4_e6",   32'(db4),   32'hF);
        check_val("start_rise4_e6", 32'(rise4), 32'hF);
        check_val("start_any4_e6",  32'(any4),  32'h1);
      end
      if (i == 7) check_val("start_rise4_e7", 32'(rise4), 32'h0);
    end

    // Bounce rejection on bit0 from all-zero, then a steady high.
    drive(4'h0, 10);
    drive(4'h1, 3);
    drive(4'h0, 1);
    drive(4'h0, 3);
    check_val("bounce_db4", 32'(db4[0]), 32'h0);
    drive(4'h1, 10);
    check_val("steady_db4", 32'(db4[0]), 32'h1);

    // Fall event on bit2 from level 4'h4.
    drive(4'h4, 10);
    drive(4'h0, 10);

    // Opposite changes on two bits in the same cycle.
    drive(4'h8, 10);
    drive(4'h2, 10);
    check_val("simul_db4", 32'(db4), 32'h2);

    // Reset in the middle of a count.
    drive(4'h0, 10);
    drive(4'h1, 3);
    do_reset(1);
    drive(4'h1, 10);

    // Minimum filter: a one-cycle glitch on bit3 reaches the STABLE_CYCLES=1 copy.
    drive(4'h0, 8);
    drive(4'h8, 1);
    drive(4'h0, 8);

    // Randomised bouncing, holds and occasional resets.
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 9))
        0: do_reset($urandom_range(1, 2));
        1, 2, 3: begin
          for (int k = 0; k < int'($urandom_range(1, 6)); k++)
            drive(4'($urandom), 1);
        end
        default: drive(4'($urandom), $urandom_range(1, 9));
      endcase
    end
    drive(sw_raw, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
